xunit_wk_source: RTL and testbench
==================================

Name: xunit_wk_source

Overview:
- Producer end of the SHA-256 round-unit word/constant interface.
- Holds one 16-word message block and, on `run`, streams 64 (W_t, K_t) pairs, one per cycle. These feed the in8/in9 operands of the compression-round functional unit.
- Generates the message schedule W_16..W_63 on the fly and takes K_t from a constant ROM.
- Sits beside the round unit in the versat datapath and shares its `run`/`delay0` configuration style.

Parameters:
- DATA_W, 32, word width; fixed by SHA-256, no other value supported.
- ROUNDS, 64, number of pairs emitted per block.
- DELAY_W, 8, width of the `delay0` start-delay configuration.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low; acts on the rising edge of clk when low
- run  in  1  one-cycle start pulse
- en  in  1  advance enable; when low the stream stalls
- delay0  in  DELAY_W  cycles to wait after run before the first pair
- msg_we  in  1  message-buffer write strobe
- msg_addr  in  4  message word index 0..15
- msg_data  in  DATA_W  message word (big-endian SHA word)
- out0  out  DATA_W  W_t
- out1  out  DATA_W  K_t
- valid  out  1  out0/out1 hold pair t this cycle
- busy  out  1  block in progress (delay or streaming)
- done  out  1  one-cycle pulse after the last pair

Behaviour:
- Reset (rst low at a clk edge):
  - State goes to IDLE.
  - out0, out1, valid, busy and done are all 0.
  - The 16-word message buffer clears to 0.
  - Round counter clears to 0.
  - Reset wins over run and msg_we in the same cycle.
- Message buffer:
  - msg_we writes msg_data to buf[msg_addr] at the clock edge, in any state.
  - Schedule window: a 16-word shift register, separate from the buffer. A write during BUSY never affects the block in flight.
- States: IDLE, DELAY, STREAM.
  - IDLE --run--> DELAY if delay0 > 0; otherwise IDLE --run--> STREAM. The window copies buf and the counter t is set to 0.
  - DELAY: the delay counter loads delay0 on run and decrements each cycle regardless of en. At 1 the state moves to STREAM.
  - STREAM: when en=1, pair t is presented and t increments. After pair ROUNDS-1 has been presented the state moves to IDLE and done pulses.
- Latency: with delay0=0, pair 0 is valid in the cycle after the run edge. With delay0=N, pair 0 is valid N+1 cycles after run.
- valid and en:
  - valid = 1 exactly in STREAM cycles with en=1.
  - With en=0, valid=0, out0/out1 hold their last values and t does not advance.
- Schedule arithmetic:
  - t<16: W_t = buf[t].
  - t>=16: W_t = σ1(W_{t-2}) + W_{t-7} + σ0(W_{t-15}) + W_{t-16}, mod 2^32.
  - σ0(x) = rotr7 ^ rotr18 ^ shr3.
  - σ1(x) = rotr17 ^ rotr19 ^ shr10.
  - The window shifts by one word per advance.
  - At most one 32-bit adder chain per cycle; no multicycle paths.
- out1 = K[t] from a 64-entry ROM, registered alongside out0.
- Outputs are registered; no combinational path from inputs to outputs.
- done:
  - Asserts in the cycle after the last valid pair, for one cycle only.
  - Its cycle is busy=0, so an IDLE-state run is accepted in the same cycle as the done pulse.
- Run while busy: abort and restart. The window reloads from the current buf, t=0, and delay reloads. No done pulse is issued for the aborted block.
- busy = 1 in DELAY and STREAM.

Decomposition:
- Package xunit_sha_pkg:
  - K constant table (64×32).
  - σ0/σ1 and rotr functions.
  - SHA_ROUNDS=64 and word-width localparams.
  - State enum.
- One natural sub-module: sha_sched_window. It is the 16-word shift register plus next-word adder, with ports load, advance, load_data[16×32], w_out.

Test Plan:
- Load the "abc" block (buf0=0x61626380, buf15=0x00000018, others 0), delay0=0, run, en=1 → cycle after run:
  - out0=0x61626380, out1=0x428a2f98.
  - pair 16: out0=0x61626380, out1=0xe49b69c1.
  - pair 17: out0=0x000f0000.
  - pair 63: out1=0xc67178f2, then done pulse, busy=0. The full 64 W values are compared against the reference model.
- delay0=5, run → valid first high 6 cycles after run; busy high from the cycle after run.
- en toggled 1,0,0,1 during STREAM → valid=0 and out0/out1 frozen while en=0; pair sequence unchanged; done arrives 2 cycles later than the en-always-high run.
- msg_we to buf0 (value 0xdeadbeef) at pair 3 → current stream unaffected; the next run's pair 0 = 0xdeadbeef.
- run again at pair 20 → next valid pair is W_0 of the current buf; no done for the aborted block; exactly 64 further valid pairs, then done.
- rst low at pair 30 → next cycle all outputs 0, state IDLE; buf reads back 0 (subsequent run emits W_0..W_15 = 0).

Source files
------------

// File: rtl/xunit_sha_pkg.sv
// Shared SHA-256 constants, types and schedule helper functions.
package xunit_sha_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SHA_ROUNDS = 64;
  localparam int unsigned DELAY_W    = 8;
  localparam int unsigned MSG_WORDS  = 16;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned T_W        = 7;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [MSG_WORDS-1:0][DATA_W-1:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_STREAM
  } state_t;

  // One (W_t, K_t) operand pair as presented to the round unit.
  typedef struct packed {
    word_t w;
    word_t k;
  } wk_pair_t;

  localparam word_t K_TABLE [SHA_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  function automatic word_t sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t k_const(input logic [5:0] idx);
    return K_TABLE[idx];
  endfunction

endpackage

// File: rtl/xunit_wk_source_if.sv
// Control, message-load and W/K output bundle of the word/constant source.
interface xunit_wk_source_if;
  import xunit_sha_pkg::*;

  logic               run;
  logic               en;
  logic [DELAY_W-1:0] delay0;
  logic               msg_we;
  logic [ADDR_W-1:0]  msg_addr;
  word_t              msg_data;
  word_t              out0;
  word_t              out1;
  logic               valid;
  logic               busy;
  logic               done;

  modport master (
    output run, en, delay0, msg_we, msg_addr, msg_data,
    input  out0, out1, valid, busy, done
  );

  modport slave (
    input  run, en, delay0, msg_we, msg_addr, msg_data,
    output out0, out1, valid, busy, done
  );
endinterface

// File: rtl/sha_sched_window.sv
// 16-word SHA-256 message-schedule window with on-the-fly next-word adder.
module sha_sched_window
  import xunit_sha_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   advance,
  input  block_t load_data,
  output word_t  w_out
);

  block_t win;
  block_t src;
  block_t shifted;
  word_t  next_word;

  // Source is the fresh block on load so a load can also advance in the same cycle.
  always_comb begin
    src       = load ? load_data : win;
    next_word = sigma1(src[14]) + src[9] + sigma0(src[1]) + src[0];
    shifted   = {next_word, src[MSG_WORDS-1:1]};
    w_out     = src[0];
  end

  // Window register: shift on advance, otherwise reload on load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      win <= '0;
    end else if (advance) begin
      win <= shifted;
    end else if (load) begin
      win <= load_data;
    end
  end

endmodule

// File: rtl/xunit_wk_source.sv
// Producer of the (W_t, K_t) operand stream for the SHA-256 round unit.
module xunit_wk_source
  import xunit_sha_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  xunit_wk_source_if.slave  bus
);

  state_t             state, state_n;
  logic [T_W-1:0]     t, t_n, t_cur;
  logic [DELAY_W-1:0] dcnt, dcnt_n;
  wk_pair_t           pair_q, pair_n;
  logic               valid_q, valid_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               emit_ok;
  logic               load;
  logic               advance;
  block_t             msg_buf;
  word_t              w_cur;

  sha_sched_window u_window (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .advance   (advance),
    .load_data (msg_buf),
    .w_out     (w_cur)
  );

  // Message buffer: writable at any time, only sampled into the window on run.
  always_ff @(posedge clk) begin
    if (!rst) begin
      msg_buf <= '0;
    end else if (bus.msg_we) begin
      msg_buf[bus.msg_addr] <= bus.msg_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      t       <= '0;
      dcnt    <= '0;
      pair_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      t       <= t_n;
      dcnt    <= dcnt_n;
      pair_q  <= pair_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Next state; a pair is registered on every edge where streaming is live and en is high.
  always_comb begin
    state_n = state;
    t_n     = t;
    dcnt_n  = dcnt;
    pair_n  = pair_q;
    valid_n = 1'b0;
    done_n  = 1'b0;
    emit_ok = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    t_cur   = '0;

    case (state)
      ST_IDLE: ;
      ST_DELAY: begin
        dcnt_n = dcnt - DELAY_W'(1);
        if (dcnt == DELAY_W'(1)) begin
          state_n = ST_STREAM;
          emit_ok = 1'b1;
        end
      end
      ST_STREAM: begin
        if (t == T_W'(SHA_ROUNDS)) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          emit_ok = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Run restarts from any state; the aborted block never signals done.
    if (bus.run) begin
      load   = 1'b1;
      t_n    = '0;
      dcnt_n = bus.delay0;
      done_n = 1'b0;
      if (bus.delay0 == '0) begin
        state_n = ST_STREAM;
        emit_ok = 1'b1;
      end else begin
        state_n = ST_DELAY;
        emit_ok = 1'b0;
      end
    end

    if (emit_ok && bus.en) begin
      t_cur    = t_n;
      advance  = 1'b1;
      pair_n.w = w_cur;
      pair_n.k = k_const(t_cur[5:0]);
      valid_n  = 1'b1;
      t_n      = t_cur + T_W'(1);
    end

    busy_n = (state_n != ST_IDLE);
  end

  assign bus.out0  = pair_q.w;
  assign bus.out1  = pair_q.k;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_xunit_wk_source.sv
// Directed self-checking bench for xunit_wk_source.
module tb_xunit_wk_source;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  logic [31:0] mblk [16];
  logic [31:0] wref [64];
  logic [31:0] kref [64];

  xunit_wk_source_if bus ();

  xunit_wk_source dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ {10'b0, x[31:10]};
  endfunction

  task automatic build_ref();
    for (int i = 0; i < 64; i++) begin
      if (i < 16) wref[i] = mblk[i];
      else        wref[i] = s1(wref[i-2]) + wref[i-7] + s0(wref[i-15]) + wref[i-16];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_pair(input string grp, input int t);
    check($sformatf("%s_valid_%0d", grp, t), {31'b0, bus.valid}, 32'd1);
    check($sformatf("%s_w_%0d", grp, t), bus.out0, wref[t]);
    check($sformatf("%s_k_%0d", grp, t), bus.out1, kref[t]);
  endtask

  task automatic check_idle(input string grp);
    check({grp, "_out0"},  bus.out0, 32'd0);
    check({grp, "_out1"},  bus.out1, 32'd0);
    check({grp, "_valid"}, {31'b0, bus.valid}, 32'd0);
    check({grp, "_busy"},  {31'b0, bus.busy},  32'd0);
    check({grp, "_done"},  {31'b0, bus.done},  32'd0);
  endtask

  task automatic write_word(input logic [3:0] a, input logic [31:0] d);
    bus.msg_we = 1'b1;
    bus.msg_addr = a;
    bus.msg_data = d;
    tick();
    bus.msg_we = 1'b0;
  endtask

  task automatic pulse_run(input logic [7:0] dly);
    bus.delay0 = dly;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
  endtask

  initial begin
    kref = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.run = 1'b0;
    bus.en = 1'b0;
    bus.delay0 = 8'd0;
    bus.msg_we = 1'b0;
    bus.msg_addr = 4'd0;
    bus.msg_data = 32'd0;

    // Reset state
    tick();
    tick();
    check_idle("reset");
    rst = 1'b1;

    // "abc" block, delay0 = 0, en held high; buf0 rewritten at pair 3
    write_word(4'd0, 32'h61626380);
    write_word(4'd15, 32'h00000018);
    for (int i = 0; i < 16; i++) mblk[i] = 32'd0;
    mblk[0] = 32'h61626380;
    mblk[15] = 32'h00000018;
    build_ref();
    bus.en = 1'b1;
    pulse_run(8'd0);
    check("abc_w0_lit", bus.out0, 32'h61626380);
    check("abc_k0_lit", bus.out1, 32'h428a2f98);
    for (int t = 0; t < 64; t++) begin
      check_pair("abc", t);
      check($sformatf("abc_busy_%0d", t), {31'b0, bus.busy}, 32'd1);
      if (t == 16) begin
        check("abc_w16_lit", bus.out0, 32'h61626380);
        check("abc_k16_lit", bus.out1, 32'he49b69c1);
      end
      if (t == 17) check("abc_w17_lit", bus.out0, 32'h000f0000);
      if (t == 63) check("abc_k63_lit", bus.out1, 32'hc67178f2);
      if (t == 3) begin
        bus.msg_we = 1'b1;
        bus.msg_addr = 4'd0;
        bus.msg_data = 32'hdeadbeef;
      end else begin
        bus.msg_we = 1'b0;
      end
      tick();
    end
    bus.msg_we = 1'b0;
    check("abc_done", {31'b0, bus.done}, 32'd1);
    check("abc_done_busy", {31'b0, bus.busy}, 32'd0);
    check("abc_done_valid", {31'b0, bus.valid}, 32'd0);
    tick();
    check("abc_done_once", {31'b0, bus.done}, 32'd0);

    // delay0 = 5, then en 1,0,0,1 stall
    mblk[0] = 32'hdeadbeef;
    build_ref();
    pulse_run(8'd5);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("dly_valid_c%0d", k), {31'b0, bus.valid}, 32'd0);
      check($sformatf("dly_busy_c%0d", k), {31'b0, bus.busy}, 32'd1);
      tick();
    end
    check_pair("dly", 0);
    check("dly_w0_lit", bus.out0, 32'hdeadbeef);
    cyc = 0;
    bus.en = 1'b0;
    tick(); cyc++;
    check("stall1_valid", {31'b0, bus.valid}, 32'd0);
    check("stall1_w", bus.out0, wref[0]);
    check("stall1_k", bus.out1, kref[0]);
    tick(); cyc++;
    check("stall2_valid", {31'b0, bus.valid}, 32'd0);
    check("stall2_w", bus.out0, wref[0]);
    check("stall2_k", bus.out1, kref[0]);
    bus.en = 1'b1;
    tick(); cyc++;
    for (int t = 1; t < 64; t++) begin
      check_pair("dly", t);
      tick(); cyc++;
    end
    check("dly_done", {31'b0, bus.done}, 32'd1);
    check("dly_done_cycles", cyc, 32'd66);

    // Abort: buf1 rewritten at pair 5, run again at pair 20
    pulse_run(8'd0);
    for (int t = 0; t <= 20; t++) begin
      check_pair("pre", t);
      check($sformatf("pre_nodone_%0d", t), {31'b0, bus.done}, 32'd0);
      if (t == 5) begin
        bus.msg_we = 1'b1;
        bus.msg_addr = 4'd1;
        bus.msg_data = 32'h01234567;
      end else begin
        bus.msg_we = 1'b0;
      end
      bus.run = (t == 20);
      tick();
    end
    bus.run = 1'b0;
    bus.msg_we = 1'b0;
    mblk[1] = 32'h01234567;
    build_ref();
    for (int t = 0; t < 64; t++) begin
      check_pair("re", t);
      check($sformatf("re_nodone_%0d", t), {31'b0, bus.done}, 32'd0);
      tick();
    end
    check("re_done", {31'b0, bus.done}, 32'd1);
    check("re_after_valid", {31'b0, bus.valid}, 32'd0);

    // Reset mid-stream at pair 30
    pulse_run(8'd0);
    for (int t = 0; t <= 30; t++) begin
      check_pair("pr", t);
      if (t == 30) rst = 1'b0;
      tick();
    end
    check_idle("mid_rst");
    rst = 1'b1;
    tick();
    check("post_rst_idle_busy", {31'b0, bus.busy}, 32'd0);
    check("post_rst_idle_valid", {31'b0, bus.valid}, 32'd0);
    for (int i = 0; i < 16; i++) mblk[i] = 32'd0;
    build_ref();
    pulse_run(8'd0);
    for (int t = 0; t < 64; t++) begin
      check_pair("zero", t);
      tick();
    end
    check("zero_done", {31'b0, bus.done}, 32'd1);
    check("zero_done_busy", {31'b0, bus.busy}, 32'd0);

    // Run accepted in the done cycle
    pulse_run(8'd0);
    check_pair("back2back", 0);
    check("back2back_busy", {31'b0, bus.busy}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
